// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute/memory/writeback and decodes datapath selects.
// Optional MULTICYCLE_CTRL_NOWRITE_EN: CMP/CMN suppress RegW and PCS in ALUWB while still writing flags.
module multicycle_ctrl #(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    HALT     = 4'd10
  } state_t;

  state_t     state, next;
  logic [3:0] cmd;
  logic [1:0] alucmd;
  logic       is_arith;
  logic       rd15;
  logic       nowrite;

  assign cmd  = Funct[4:1];
  assign rd15 = (Rd == 4'd15);

  always_comb begin
    alucmd   = 2'b00;
    is_arith = 1'b0;
    case (cmd)
      4'b0100, 4'b1011: begin alucmd = 2'b00; is_arith = 1'b1; end
      4'b0010, 4'b1010: begin alucmd = 2'b01; is_arith = 1'b1; end
      4'b0000:          alucmd = 2'b10;
      4'b1100:          alucmd = 2'b11;
      default:          alucmd = 2'b00;
    endcase
  end

`ifdef MULTICYCLE_CTRL_NOWRITE_EN
  assign nowrite = (Op == 2'b00) && ((cmd == 4'b1010) || (cmd == 4'b1011));
`else
  assign nowrite = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next;
  end

  always_comb begin
    next       = FETCH;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ImmSrc     = Op;
    RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
    PCS        = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    FlagW      = 2'b00;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        next      = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   next = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   next = MEMADR;
          2'b10:   next = BRANCH;
          default: next = HALT_ON_UNDEF ? HALT : FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        next    = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next   = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        PCS       = rd15;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        ALUControl = alucmd;
        next       = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alucmd;
        next       = ALUWB;
      end
      ALUWB: begin
        ALUControl = alucmd;
        RegW       = ~nowrite;
        PCS        = ~nowrite & rd15;
        FlagW      = {Funct[0], Funct[0] & is_arith};
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCS       = 1'b1;
      end
      HALT: begin
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
        next   = HALT;
      end
      default: begin
        next = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: per-instruction expected output sequences
// are built from the instruction class and compared cycle by cycle; a second instance checks HALT.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] alucontrol;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic [1:0] flagw;
  } ov_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       reset_h = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = '0;
  logic [3:0] Rd = '0;

  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc, FlagW;
  logic       h_IRWrite, h_NextPC, h_AdrSrc, h_ALUSrcA, h_PCS, h_RegW, h_MemW;
  logic [1:0] h_ResultSrc, h_ALUSrcB, h_ALUControl, h_ImmSrc, h_RegSrc, h_FlagW;

  ov_t obs, obs_h;
  assign obs   = {IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
                  ImmSrc, RegSrc, PCS, RegW, MemW, FlagW};
  assign obs_h = {h_IRWrite, h_NextPC, h_AdrSrc, h_ResultSrc, h_ALUSrcA, h_ALUSrcB, h_ALUControl,
                  h_ImmSrc, h_RegSrc, h_PCS, h_RegW, h_MemW, h_FlagW};

  multicycle_ctrl #(.HALT_ON_UNDEF(1'b0)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW)
  );

  multicycle_ctrl #(.HALT_ON_UNDEF(1'b1)) dut_halt (
    .clk(clk), .reset(reset_h), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(h_IRWrite), .NextPC(h_NextPC), .AdrSrc(h_AdrSrc), .ResultSrc(h_ResultSrc),
    .ALUSrcA(h_ALUSrcA), .ALUSrcB(h_ALUSrcB), .ALUControl(h_ALUControl), .ImmSrc(h_ImmSrc),
    .RegSrc(h_RegSrc), .PCS(h_PCS), .RegW(h_RegW), .MemW(h_MemW), .FlagW(h_FlagW)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  ov_t expq[$];

  task automatic check(input string tag, input ov_t got, input ov_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%b required=%b", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 2'b01;
      4'b0000:          return 2'b10;
      4'b1100:          return 2'b11;
      default:          return 2'b00;
    endcase
  endfunction

  function automatic ov_t blank(input logic [1:0] op);
    ov_t v = '0;
    v.immsrc = op;
    v.regsrc = {op == 2'b01, op == 2'b10};
    return v;
  endfunction

  // Expected outputs for every cycle of one instruction, starting at its FETCH cycle.
  task automatic build(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    ov_t v;
    logic [3:0] cmd = funct[4:1];
    logic s = funct[0];
    logic arith = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010) || (cmd == 4'b1011);
    logic wr = 1'b1;
`ifdef MULTICYCLE_CTRL_NOWRITE_EN
    if (cmd == 4'b1010 || cmd == 4'b1011) wr = 1'b0;
`endif
    expq.delete();
    v = blank(op); v.irwrite = 1; v.nextpc = 1; v.alusrca = 1; v.alusrcb = 2; v.resultsrc = 2;
    expq.push_back(v);
    v = blank(op); v.alusrca = 1; v.alusrcb = 2; v.resultsrc = 2;
    expq.push_back(v);
    case (op)
      2'b00: begin
        v = blank(op); v.alusrcb = funct[5] ? 2'b01 : 2'b00; v.alucontrol = alu_of(cmd);
        expq.push_back(v);
        v = blank(op); v.alucontrol = alu_of(cmd); v.regw = wr; v.pcs = wr && (rd == 15);
        v.flagw = {s, s & arith};
        expq.push_back(v);
      end
      2'b01: begin
        v = blank(op); v.alusrcb = 2'b01;
        expq.push_back(v);
        if (s) begin
          v = blank(op); v.adrsrc = 1;
          expq.push_back(v);
          v = blank(op); v.resultsrc = 2'b01; v.regw = 1; v.pcs = (rd == 15);
          expq.push_back(v);
        end else begin
          v = blank(op); v.adrsrc = 1; v.memw = 1;
          expq.push_back(v);
        end
      end
      2'b10: begin
        v = blank(op); v.alusrcb = 2'b01; v.resultsrc = 2'b10; v.pcs = 1;
        expq.push_back(v);
      end
      default: ;
    endcase
  endtask

  // Entered just after the edge that puts the DUT in FETCH.
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd);
    build(op, funct, rd);
    Op = op; Funct = funct; Rd = rd;
    foreach (expq[i]) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", name, i), obs, expq[i]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [3:0] cmds [6] = '{4'b0100, 4'b0010, 4'b1010, 4'b1011, 4'b0000, 4'b1100};
    logic [5:0] f;
    logic [3:0] r;
    logic [1:0] o;
    ov_t fv;

    Op = 2'b00; Funct = 6'b001000; Rd = 4'd1;
    #12;
    build(Op, Funct, Rd);
    check("reset_state", obs, expq[0]);
    @(posedge clk); #1 reset = 1'b1;

    // ADD interrupted by reset while in EXECUTER
    foreach (expq[i]) begin
      if (i < 3) begin
        @(negedge clk);
        check($sformatf("addint_c%0d", i), obs, expq[i]);
        if (i < 2) begin @(posedge clk); #1; end
      end
    end
    reset = 1'b0; #1;
    check("reset_async", obs, expq[0]);
    @(posedge clk); #1;
    check("reset_hold", obs, expq[0]);
    reset = 1'b1;

    run_instr("add",  2'b00, 6'b001000, 4'd1);
    run_instr("subs", 2'b00, 6'b100101, 4'd15);
    run_instr("ldr",  2'b01, 6'b011001, 4'd3);
    run_instr("str",  2'b01, 6'b011000, 4'd4);
    run_instr("b",    2'b10, 6'b000000, 4'd0);
    run_instr("undef", 2'b11, 6'b000000, 4'd0);
    run_instr("cmp",  2'b00, 6'b010101, 4'd15);

    for (int n = 0; n < 80; n++) begin
      o = 2'($urandom_range(0, 3));
      f = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) f[4:1] = cmds[$urandom_range(0, 5)];
      r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      run_instr($sformatf("rnd%0d", n), o, f, r);
    end

    @(negedge clk);
    build(Op, Funct, Rd);
    check("final_fetch", obs, expq[0]);

    // HALT_ON_UNDEF=1 instance: undefined op parks in HALT until reset
    @(posedge clk); #1 reset_h = 1'b1;
    Op = 2'b11; Funct = 6'b010101; Rd = 4'd7;
    build(Op, Funct, Rd);
    fv = expq[0];
    @(negedge clk); check("halt_fetch", obs_h, expq[0]);
    @(posedge clk); #1;
    @(negedge clk); check("halt_decode", obs_h, expq[1]);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      Op = 2'($urandom_range(0, 3));
      @(negedge clk); check($sformatf("halt_stay%0d", k), obs_h, '0);
    end
    Op = 2'b11;
    reset_h = 1'b0; #1;
    check("halt_reset", obs_h, fv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle ARM control unit. It sits directly upstream of condlogic and drives its PCS, RegW, MemW and FlagW inputs.
- A Moore FSM sequences fetch, decode, execute, memory and writeback. It also produces the datapath mux selects and the ALU control.
- Decoding uses the held instruction-register fields Op, Funct and Rd. Condition gating stays in condlogic.

Parameters:
- HALT_ON_UNDEF, 0: when 1, Op=2'b11 enters HALT and stays there until reset. When 0, Op=2'b11 returns to FETCH with no side effects.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S/L.
- Rd  in  4  Instr[15:12].
- IRWrite  out  1  instruction register load.
- NextPC  out  1  unconditional PC update (PC+4).
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- ResultSrc  out  2  result select: 00=ALUOut, 01=ReadData, 10=ALUResult.
- ALUSrcA  out  1  ALU A select: 0=RD1, 1=PC.
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ExtImm, 10=const 4.
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR.
- ImmSrc  out  2  equal to Op.
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
- PCS  out  1  to condlogic.
- RegW  out  1  to condlogic.
- MemW  out  1  to condlogic.
- FlagW  out  2  to condlogic.

Behaviour:
- State register is 4 bits.
- Reset asserted (async, any time, including mid-instruction): state=FETCH immediately. All outputs are the FETCH decode.
- Outputs are a pure decode of state plus the held instruction fields; no output registers. Signals not listed for a state are 0.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state by Op:
  - Op=00, Funct[5]=0: EXECUTER.
  - Op=00, Funct[5]=1: EXECUTEI.
  - Op=01: MEMADR.
  - Op=10: BRANCH.
  - Op=11: FETCH, or HALT when HALT_ON_UNDEF=1.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00. Funct[0]=1 goes to MEMREAD; Funct[0]=0 goes to MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegW=1, PCS=(Rd==15). Next state is FETCH.
- MEMWRITE: AdrSrc=1, MemW=1. Next state is FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUControl from cmd. Next state is ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUControl from cmd. Next state is ALUWB.
- ALUWB: ResultSrc=00, ALUControl from cmd, RegW=1, PCS=(Rd==15).
  - FlagW[1]=S sets the N and Z flags.
  - FlagW[0]=S & (cmd is ADD/SUB/CMP/CMN) sets the C and V flags.
  - Next state is FETCH.
  - FlagW and RegW share this one cycle, so condlogic evaluates CondEx once, against the old flags.
  - The datapath registers ALUFlags alongside ALUOut.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUControl=00, PCS=1. Next state is FETCH.
- HALT: all outputs 0; self-loop.
- cmd decode:
  - 0100 ADD and 1011 CMN give 00.
  - 0010 SUB and 1010 CMP give 01.
  - 0000 AND gives 10.
  - 1100 ORR gives 11.
  - Any other cmd gives 00.
- Latency in cycles: LDR 5, STR 4, data processing 4, branch 3, undefined 2.
- Illegal state encodings go to FETCH on the next edge.

Optional Feature:
- Macro: MULTICYCLE_CTRL_NOWRITE_EN.
- Defined: for Op=00 with cmd CMP or CMN, RegW=0 and PCS=0 in ALUWB; FlagW is still asserted.
- Undefined: CMP/CMN assert RegW exactly like other data-processing ops.

Test Plan:
- Reset=0 held during EXECUTER, then released -> state=FETCH at once; IRWrite=1, NextPC=1, RegW=MemW=PCS=0.
- ADD R1,R2,R3 (Op=00, Funct=001000, Rd=1) -> FETCH, DECODE, EXECUTER, ALUWB, FETCH; ALUControl=00; RegW=1 only in ALUWB; FlagW=00; PCS=0.
- SUBS imm into R15 (Op=00, Funct=100101, Rd=15) -> EXECUTEI path; in ALUWB: ALUControl=01, FlagW=11, RegW=1, PCS=1.
- LDR then STR (Op=01, Funct[0]=1 then 0) -> LDR passes MEMADR, MEMREAD, MEMWB with ResultSrc=01 and RegW=1. STR passes MEMADR, MEMWRITE with MemW=1 and AdrSrc=1, and RegW stays 0.
- B (Op=10) -> DECODE, BRANCH, FETCH; PCS=1 exactly 1 cycle; ALUSrcB=01.
- Op=11 with HALT_ON_UNDEF=0 -> back to FETCH after 2 cycles. With HALT_ON_UNDEF=1 -> HALT with all outputs 0 until reset=0.
